regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Arbitrates the single write-back port of the 16 x 32-bit register file between two requesters: A (ALU result) and B (load data from memory).
- Grants one write per cycle, using round-robin priority.
- Drives the per-register ENABLE lines, WR_ADDR and WR_DATA that feed the bank of 32-bit enable registers.
- Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, write data width
ADDR_W, 4, register address width
NREGS, 16, number of registers; must equal 2**ADDR_W

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
HOLD  in  1  pipeline stall; blocks new grants
REQ_A  in  1  requester A write request
ADDR_A  in  ADDR_W  A destination register
DATA_A  in  DATA_W  A write data
GNT_A  out  1  one-cycle grant pulse to A
REQ_B  in  1  requester B write request
ADDR_B  in  ADDR_W  B destination register
DATA_B  in  DATA_W  B write data
GNT_B  out  1  one-cycle grant pulse to B
WR_EN  out  1  write strobe to register file
WR_ADDR  out  ADDR_W  selected register
WR_DATA  out  DATA_W  selected data
REG_EN  out  NREGS  one-hot enable, bit WR_ADDR set when WR_EN=1

Behaviour:
- Interface: one clock, CLK; RESET is asynchronous and active-high.
- RESET=1 acts immediately, without waiting for a clock edge:
  - GNT_A, GNT_B, WR_EN, WR_ADDR, WR_DATA and REG_EN all go to 0.
  - FSM goes to IDLE; round-robin pointer LAST goes to B, so A wins the first tie.
  - Deasserting RESET mid-stream discards any in-flight grant; requesters must re-present.
- FSM states:
  - IDLE: no write this cycle.
  - WR_A: writing A's captured request.
  - WR_B: writing B's captured request.
- Output timing:
  - All outputs are registered and decoded from the state plus captured address/data.
  - Latency is 1 cycle from the edge that samples REQ to the cycle in which GNT and WR_EN are high.
- Eligibility, evaluated at each rising edge:
  - Requester x is eligible if REQ_x=1 and GNT_x is not currently high.
  - A requester being granted this cycle is not re-granted at the next edge. Its asserted REQ in that cycle belongs to the completing request.
- Transitions, from any state:
  - HOLD=1 -> IDLE.
  - Otherwise, only one requester eligible -> WR_<that requester>.
  - Otherwise, both eligible -> WR_<requester not equal to LAST>.
  - Otherwise, neither eligible -> IDLE.
- On entering WR_x:
  - Capture ADDR_x and DATA_x into WR_ADDR and WR_DATA.
  - Set LAST=x.
- In WR_x:
  - WR_EN=1, GNT_x=1, REG_EN = 1 << WR_ADDR.
  - Exactly one GNT is high at any time.
- In IDLE: WR_EN=0 and REG_EN=0. WR_ADDR and WR_DATA hold their last values.
- Handshake:
  - Requesters hold REQ, ADDR and DATA stable until they see GNT.
  - After GNT, a requester may drop REQ or present a new request.
  - Maximum rate is one write per 2 cycles per requester, and 1 write per cycle aggregate when both requesters are active.
- HOLD:
  - HOLD arriving while in WR_x does not cancel that write; the write completes in that cycle.
  - Pending requests wait, with no loss, until HOLD=0.
- Same destination address from A and B:
  - Both writes are performed, in grant order, back-to-back.
  - The later grant's data remains in the register.
- Address range: ADDR values are always less than NREGS. No range check is done; REG_EN is a full decode of the address.
- Widths: no arithmetic; all buses pass through at full width.

Test Plan:
- Single requester: REQ_A=1, ADDR_A=3, DATA_A=0xDEADBEEF for one edge -> the next cycle has GNT_A=1, WR_EN=1, WR_ADDR=3, WR_DATA=0xDEADBEEF, REG_EN=0x0008. The cycle after has WR_EN=0 and REG_EN=0.
- Tie after reset: REQ_A and REQ_B both asserted (A: R1/0x11, B: R2/0x22) and held -> GNT_A, then GNT_B, then GNT_A, strictly alternating. REG_EN sequence is 0x0002, 0x0004, 0x0002, and so on. No idle cycles.
- Continuous single requester: REQ_B held high with no other traffic -> GNT_B is high every other cycle (1,0,1,0).
- HOLD: both requests pending with HOLD=1 for 3 cycles -> no GNT and WR_EN=0 for those 3 cycles. The first edge after HOLD=0 grants per LAST. HOLD asserted during WR_A still completes the A write.
- Same-address collision: A (R5, 0xAAAA0000) and B (R5, 0xBBBB0000) requested together -> two consecutive writes to R5, A first, and final register contents are 0xBBBB0000.
- Asynchronous reset: RESET pulsed between clock edges while in WR_B -> GNT_B, WR_EN and REG_EN drop to 0 immediately, without waiting for an edge. After release, a tie is granted to A first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back port arbiter for the 16 x 32-bit register file.
//
// Two requesters share the single register-file write port:
//   A - ALU result, B - load data from memory.
// One write is granted per cycle, with round-robin priority on ties.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous active-high reset
//   HOLD     in   pipeline stall, blocks new grants
//   REQ_A/B  in   write request from requester A/B
//   ADDR_A/B in   destination register of A/B
//   DATA_A/B in   write data of A/B
//   GNT_A/B  out  one-cycle grant pulse to A/B
//   WR_EN    out  register-file write strobe
//   WR_ADDR  out  selected register
//   WR_DATA  out  selected data
//   REG_EN   out  one-hot per-register enable, zero when WR_EN=0
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NREGS  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HOLD,
  input  logic              REQ_A,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [DATA_W-1:0] DATA_A,
  output logic              GNT_A,
  input  logic              REQ_B,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] DATA_B,
  output logic              GNT_B,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [NREGS-1:0]  REG_EN
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWrA  = 2'd1,
    StWrB  = 2'd2
  } state_e;

  // Encoding of the round-robin pointer: which requester was granted last.
  localparam logic LastA = 1'b0;
  localparam logic LastB = 1'b1;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic elig_a, elig_b;

  // A requester in its grant cycle still shows REQ for the request being
  // completed, so it must not be granted again at the next edge.
  assign elig_a = REQ_A && (state_q != StWrA);
  assign elig_b = REQ_B && (state_q != StWrB);

  always_comb begin
    state_d   = StIdle;
    last_d    = last_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!HOLD) begin
      if (elig_a && (!elig_b || (last_q == LastB))) begin
        state_d   = StWrA;
        last_d    = LastA;
        wr_addr_d = ADDR_A;
        wr_data_d = DATA_A;
      end else if (elig_b) begin
        state_d   = StWrB;
        last_d    = LastB;
        wr_addr_d = ADDR_B;
        wr_data_d = DATA_B;
      end
    end
  end

  // Reset leaves LAST pointing at B so that A wins the first tie.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      last_q    <= LastB;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  always_comb begin
    GNT_A   = (state_q == StWrA);
    GNT_B   = (state_q == StWrB);
    WR_EN   = (state_q != StIdle);
    WR_ADDR = wr_addr_q;
    WR_DATA = wr_data_q;
    REG_EN  = '0;
    if (WR_EN) begin
      REG_EN = {{(NREGS-1){1'b0}}, 1'b1} << wr_addr_q;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 16;

  logic              CLK;
  logic              RESET;
  logic              HOLD;
  logic              REQ_A, REQ_B;
  logic [ADDR_W-1:0] ADDR_A, ADDR_B;
  logic [DATA_W-1:0] DATA_A, DATA_B;
  logic              GNT_A, GNT_B;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic [NREGS-1:0]  REG_EN;

  int n_checks = 0;
  int n_fails  = 0;

  // Register file fed by the arbiter outputs.
  logic [DATA_W-1:0] rf [NREGS];

  regfile_wb_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .HOLD    (HOLD),
    .REQ_A   (REQ_A),
    .ADDR_A  (ADDR_A),
    .DATA_A  (DATA_A),
    .GNT_A   (GNT_A),
    .REQ_B   (REQ_B),
    .ADDR_B  (ADDR_B),
    .DATA_B  (DATA_B),
    .GNT_B   (GNT_B),
    .WR_EN   (WR_EN),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .REG_EN  (REG_EN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    for (int i = 0; i < int'(NREGS); i++) begin
      if (WR_EN && REG_EN[i]) rf[i] <= WR_DATA;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
  endtask

  task automatic check_write(input string tag, input logic ga, input logic gb,
                             input logic [3:0] addr, input logic [31:0] data);
    check({tag, ".gnt_a"}, 32'(GNT_A), 32'(ga));
    check({tag, ".gnt_b"}, 32'(GNT_B), 32'(gb));
    check({tag, ".wr_en"}, 32'(WR_EN), 32'(1'b1));
    check({tag, ".wr_addr"}, 32'(WR_ADDR), 32'(addr));
    check({tag, ".wr_data"}, WR_DATA, data);
    check({tag, ".reg_en"}, 32'(REG_EN), 32'(1) << addr);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt_a"}, 32'(GNT_A), 32'(0));
    check({tag, ".gnt_b"}, 32'(GNT_B), 32'(0));
    check({tag, ".wr_en"}, 32'(WR_EN), 32'(0));
    check({tag, ".reg_en"}, 32'(REG_EN), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < int'(NREGS); i++) rf[i] = '0;
    RESET = 1'b1; HOLD = 1'b0;
    REQ_A = 1'b0; ADDR_A = '0; DATA_A = '0;
    REQ_B = 1'b0; ADDR_B = '0; DATA_B = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check_idle("rst");
    check("rst.wr_addr", 32'(WR_ADDR), 32'(0));
    check("rst.wr_data", WR_DATA, 32'h0);
    #2;
    RESET = 1'b0;
    tick();

    // Single requester
    REQ_A = 1'b1; ADDR_A = 4'd3; DATA_A = 32'hDEADBEEF;
    tick();
    check_write("single", 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
    check("single.reg_en_lit", 32'(REG_EN), 32'h0008);
    REQ_A = 1'b0;
    tick();
    check_idle("single_after");
    check("single_after.addr_hold", 32'(WR_ADDR), 32'(3));
    check("single_after.data_hold", WR_DATA, 32'hDEADBEEF);

    // Tie after reset: strict alternation starting with A
    pulse_reset();
    REQ_A = 1'b1; ADDR_A = 4'd1; DATA_A = 32'h11;
    REQ_B = 1'b1; ADDR_B = 4'd2; DATA_B = 32'h22;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) check_write($sformatf("tie%0d", i), 1'b1, 1'b0, 4'd1, 32'h11);
      else            check_write($sformatf("tie%0d", i), 1'b0, 1'b1, 4'd2, 32'h22);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    check_idle("tie_end");

    // Continuous single requester B: grant every other cycle
    REQ_B = 1'b1; ADDR_B = 4'd7; DATA_B = 32'h0000_0777;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("contb%0d.gnt_b", i), 32'(GNT_B), 32'(i % 2 == 0));
      check($sformatf("contb%0d.gnt_a", i), 32'(GNT_A), 32'(0));
    end
    REQ_B = 1'b0;
    tick();
    check_idle("contb_end");

    // HOLD with both pending; LAST is B so A goes first
    HOLD = 1'b1;
    REQ_A = 1'b1; ADDR_A = 4'd9;  DATA_A = 32'hA9A9A9A9;
    REQ_B = 1'b1; ADDR_B = 4'd10; DATA_B = 32'hB0B0B0B0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("hold%0d", i));
    end
    HOLD = 1'b0;
    tick();
    check_write("hold_rel", 1'b1, 1'b0, 4'd9, 32'hA9A9A9A9);
    REQ_A = 1'b0;
    HOLD = 1'b1;
    #1;
    check_write("hold_in_wra", 1'b1, 1'b0, 4'd9, 32'hA9A9A9A9);
    tick();
    check_idle("hold_again");
    HOLD = 1'b0;
    tick();
    check_write("hold_b_kept", 1'b0, 1'b1, 4'd10, 32'hB0B0B0B0);
    REQ_B = 1'b0;
    tick();
    check_idle("hold_end");

    // Same-address collision: A then B, B's data remains
    pulse_reset();
    REQ_A = 1'b1; ADDR_A = 4'd5; DATA_A = 32'hAAAA0000;
    REQ_B = 1'b1; ADDR_B = 4'd5; DATA_B = 32'hBBBB0000;
    tick();
    check_write("coll_a", 1'b1, 1'b0, 4'd5, 32'hAAAA0000);
    REQ_A = 1'b0;
    tick();
    check_write("coll_b", 1'b0, 1'b1, 4'd5, 32'hBBBB0000);
    check("coll.rf5_mid", rf[5], 32'hAAAA0000);
    REQ_B = 1'b0;
    tick();
    check_idle("coll_end");
    check("coll.rf5_final", rf[5], 32'hBBBB0000);

    // Asynchronous reset during WR_B
    REQ_B = 1'b1; ADDR_B = 4'd12; DATA_B = 32'hC0FFEE00;
    tick();
    check_write("arst_pre", 1'b0, 1'b1, 4'd12, 32'hC0FFEE00);
    #2;
    RESET = 1'b1;
    #1;
    check_idle("arst_now");
    #1;
    RESET = 1'b0;
    REQ_A = 1'b1; ADDR_A = 4'd14; DATA_A = 32'h0000_AAAA;
    REQ_B = 1'b1; ADDR_B = 4'd15; DATA_B = 32'h0000_BBBB;
    tick();
    check_write("arst_tie", 1'b1, 1'b0, 4'd14, 32'h0000_AAAA);
    REQ_A = 1'b0;
    tick();
    check_write("arst_tie_b", 1'b0, 1'b1, 4'd15, 32'h0000_BBBB);
    check("arst.reg_en_lit", 32'(REG_EN), 32'h8000);
    REQ_B = 1'b0;
    tick();
    check_idle("arst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
